frame_aligner: RTL and testbench
================================

Name: frame_aligner

Overview:
- Word-alignment controller sitting directly downstream of the Spartan-6 ISERDES top.
- Monitors the deserialized frame-clock word `clk_data_out` in the `sample_clk` domain.
- Issues single-cycle `bitslip` pulses back to the ISERDES until the word equals the frame pattern, then asserts `aligned`.
- Supervises lock afterwards and re-aligns on loss.

Parameters:
- TARGET, 8'h0F: expected frame-clock word when aligned.
- SETTLE_CYCLES, 4: sample_clk cycles ignored after each bitslip (ISERDES pipeline flush); range 1..15.
- LOCK_COUNT, 16: consecutive TARGET matches required to declare lock; range 1..255.
- LOSS_COUNT, 4: consecutive mismatches in LOCKED that drop lock; range 1..255.
- MAX_SLIPS, 8: bitslips attempted per alignment run before failure; range 1..15.

Ports:
- sample_clk  in  1  word clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- enable  in  1  run alignment; low forces IDLE.
- clk_data_out  in  8  deserialized frame-clock word from the ISERDES.
- bitslip  out  1  one-cycle pulse to the ISERDES bitslip input.
- aligned  out  1  high while in LOCKED.
- align_err  out  1  high while in FAIL.
- slip_count  out  4  bitslips issued in the current run.

Behaviour:
- Reset (reset_n low at a rising edge), all taking effect at that edge:
  - state=IDLE.
  - bitslip=0, aligned=0, align_err=0, slip_count=0.
  - All internal counters cleared.
  - Reset overrides every other input in every state, including mid-SETTLE.
- All outputs are registered.
- IDLE:
  - Outputs 0, counters cleared.
  - enable=1 -> CHECK on the next cycle.
- CHECK, evaluated every cycle:
  - clk_data_out==TARGET: match_cnt++. When match_cnt reaches LOCK_COUNT -> LOCKED; aligned=1 on the cycle after the LOCK_COUNT-th matching sample.
  - Mismatch with slip_count<MAX_SLIPS -> SLIP; match_cnt=0.
  - Mismatch with slip_count==MAX_SLIPS -> FAIL.
- SLIP:
  - Lasts exactly one cycle with bitslip=1.
  - slip_count++ at the same edge.
  - -> SETTLE.
- SETTLE:
  - Counts SETTLE_CYCLES cycles with clk_data_out ignored, then -> CHECK.
  - Consecutive bitslip pulses are therefore separated by at least SETTLE_CYCLES+1 low cycles.
- LOCKED:
  - aligned=1.
  - Mismatch: loss_cnt++. Match: loss_cnt=0.
  - loss_cnt reaching LOSS_COUNT -> CHECK with aligned=0 and slip_count=0, match_cnt=0, loss_cnt=0 (a fresh run).
  - Isolated glitches shorter than LOSS_COUNT do not affect aligned.
- FAIL:
  - align_err=1, bitslip=0.
  - Held until enable=0, which gives IDLE.
  - No automatic retry.
- enable=0 in any state:
  - -> IDLE next cycle.
  - Outputs and counters cleared next cycle.
  - A SLIP cycle already registered completes its single pulse; no further pulse is issued.
- bitslip is never high two consecutive cycles.
- bitslip is never high in LOCKED, FAIL or IDLE.
- Counters never wrap: match_cnt and loss_cnt stop at their thresholds, and slip_count is bounded by MAX_SLIPS.

Optional Feature:
- Macro: FRAME_ALIGNER_STATS_EN.
- When defined, two extra output ports are added:
  - slip_total (out, 16): total bitslips since reset, saturating at 16'hFFFF, not cleared by enable.
  - lock_losses (out, 8): LOCKED->CHECK transitions since reset, saturating at 8'hFF.
  - Both are cleared only by reset_n.
- When undefined, these ports and counters are absent, and core behaviour is identical.

Test Plan:
- Reset and enable: reset_n=0 with enable=1 and random input -> all outputs 0. Release with clk_data_out=8'h0F constant -> no bitslip; aligned rises 16 cycles after entering CHECK; slip_count=0.
- Slip to alignment: the bench model rotates the word left by 1 per bitslip, starting at 8'h3C (needs 6 slips) -> exactly 6 bitslip pulses, each 1 cycle wide and spaced at least 5 cycles apart; slip_count=6; aligned=1.
- Failure: input held at 8'h55 -> exactly 8 pulses, then align_err=1, slip_count=8, no further pulses. Drop enable -> IDLE, align_err=0. Raise enable -> a new run starts.
- Lock supervision: once locked, inject 3 consecutive mismatches -> aligned stays 1. Inject 4 consecutive mismatches -> aligned=0 on the following cycle, re-alignment begins, slip_count restarts from 0.
- Mid-operation abort: deassert reset_n during SETTLE, and separately deassert enable during SLIP -> reset gives all outputs 0 at the next edge; enable drop completes the single pulse only, then IDLE.
- With FRAME_ALIGNER_STATS_EN: run the slip-to-alignment and lock-supervision scenarios back to back -> slip_total=12 (6+6), lock_losses=1.

Source files
------------

// File: rtl/frame_aligner.sv
// Word-alignment controller for the ISERDES frame-clock word: bitslips until the word
// matches TARGET, then supervises lock. Define FRAME_ALIGNER_STATS_EN to add the statistics outputs.
module frame_aligner #(
    parameter logic [7:0] TARGET        = 8'h0F,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         LOCK_COUNT    = 16,
    parameter int         LOSS_COUNT    = 4,
    parameter int         MAX_SLIPS     = 8
) (
    input  logic        sample_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  clk_data_out,
    output logic        bitslip,
    output logic        aligned,
    output logic        align_err,
    output logic [3:0]  slip_count
`ifdef FRAME_ALIGNER_STATS_EN
    ,
    output logic [15:0] slip_total,
    output logic [7:0]  lock_losses
`endif
);

    localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);
    localparam logic [7:0] LOCK_N   = 8'(LOCK_COUNT);
    localparam logic [7:0] LOSS_N   = 8'(LOSS_COUNT);
    localparam logic [3:0] MAX_N    = 4'(MAX_SLIPS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        SLIP   = 3'd2,
        SETTLE = 3'd3,
        LOCKED = 3'd4,
        FAIL   = 3'd5
    } state_t;

    state_t      state_q;
    logic        bitslip_q;
    logic        aligned_q;
    logic        align_err_q;
    logic [3:0]  slip_count_q;
    logic [3:0]  settle_cnt_q;
    logic [7:0]  match_cnt_q;
    logic [7:0]  loss_cnt_q;
`ifdef FRAME_ALIGNER_STATS_EN
    logic [15:0] slip_total_q;
    logic [7:0]  lock_losses_q;
`endif

    logic word_match;
    assign word_match = (clk_data_out == TARGET);

    always_ff @(posedge sample_clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            bitslip_q     <= 1'b0;
            aligned_q     <= 1'b0;
            align_err_q   <= 1'b0;
            slip_count_q  <= 4'd0;
            settle_cnt_q  <= 4'd0;
            match_cnt_q   <= 8'd0;
            loss_cnt_q    <= 8'd0;
`ifdef FRAME_ALIGNER_STATS_EN
            slip_total_q  <= 16'd0;
            lock_losses_q <= 8'd0;
`endif
        end else if (!enable) begin
            // Statistics deliberately survive an enable drop.
            state_q      <= IDLE;
            bitslip_q    <= 1'b0;
            aligned_q    <= 1'b0;
            align_err_q  <= 1'b0;
            slip_count_q <= 4'd0;
            settle_cnt_q <= 4'd0;
            match_cnt_q  <= 8'd0;
            loss_cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= CHECK;
                end
                CHECK: begin
                    if (word_match) begin
                        if (match_cnt_q >= LOCK_N - 8'd1) begin
                            state_q     <= LOCKED;
                            aligned_q   <= 1'b1;
                            match_cnt_q <= LOCK_N;
                            loss_cnt_q  <= 8'd0;
                        end else begin
                            match_cnt_q <= match_cnt_q + 8'd1;
                        end
                    end else if (slip_count_q < MAX_N) begin
                        state_q      <= SLIP;
                        bitslip_q    <= 1'b1;
                        slip_count_q <= slip_count_q + 4'd1;
                        match_cnt_q  <= 8'd0;
`ifdef FRAME_ALIGNER_STATS_EN
                        if (slip_total_q != 16'hFFFF) begin
                            slip_total_q <= slip_total_q + 16'd1;
                        end
`endif
                    end else begin
                        state_q     <= FAIL;
                        align_err_q <= 1'b1;
                        match_cnt_q <= 8'd0;
                    end
                end
                SLIP: begin
                    state_q      <= SETTLE;
                    bitslip_q    <= 1'b0;
                    settle_cnt_q <= 4'd0;
                end
                SETTLE: begin
                    // The word is ignored here while the ISERDES pipeline flushes.
                    if (settle_cnt_q >= SETTLE_N - 4'd1) begin
                        state_q      <= CHECK;
                        settle_cnt_q <= 4'd0;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 4'd1;
                    end
                end
                LOCKED: begin
                    if (word_match) begin
                        loss_cnt_q <= 8'd0;
                    end else if (loss_cnt_q >= LOSS_N - 8'd1) begin
                        state_q      <= CHECK;
                        aligned_q    <= 1'b0;
                        slip_count_q <= 4'd0;
                        match_cnt_q  <= 8'd0;
                        loss_cnt_q   <= 8'd0;
`ifdef FRAME_ALIGNER_STATS_EN
                        if (lock_losses_q != 8'hFF) begin
                            lock_losses_q <= lock_losses_q + 8'd1;
                        end
`endif
                    end else begin
                        loss_cnt_q <= loss_cnt_q + 8'd1;
                    end
                end
                FAIL: begin
                    state_q     <= FAIL;
                    align_err_q <= 1'b1;
                    bitslip_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign align_err  = align_err_q;
    assign slip_count = slip_count_q;
`ifdef FRAME_ALIGNER_STATS_EN
    assign slip_total  = slip_total_q;
    assign lock_losses = lock_losses_q;
`endif

endmodule

// File: tb/tb_frame_aligner.sv
// Bench for frame_aligner: an ISERDES model rotates the word per bitslip pulse and
// lock/fail timing is predicted from slip count arithmetic.
module tb_frame_aligner;

    localparam logic [7:0] TGT    = 8'h0F;
    localparam int         SETTLE = 4;
    localparam int         LOCKN  = 16;
    localparam int         MAXS   = 8;

    logic        sample_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  clk_data_out;
    logic        bitslip;
    logic        aligned;
    logic        align_err;
    logic [3:0]  slip_count;
`ifdef FRAME_ALIGNER_STATS_EN
    logic [15:0] slip_total;
    logic [7:0]  lock_losses;
`endif

    frame_aligner dut (
        .sample_clk   (sample_clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .clk_data_out (clk_data_out),
        .bitslip      (bitslip),
        .aligned      (aligned),
        .align_err    (align_err),
        .slip_count   (slip_count)
`ifdef FRAME_ALIGNER_STATS_EN
        ,
        .slip_total   (slip_total),
        .lock_losses  (lock_losses)
`endif
    );

    always #5 sample_clk = ~sample_clk;

    int checks   = 0;
    int failures = 0;

    // ISERDES model: word = base rotated left once per pulse since pulse_base.
    logic [7:0] base_word  = TGT;
    int         pulse_base = 0;
    logic       ovr_en     = 1'b1;
    logic [7:0] ovr_val    = 8'h00;

    int   pulse_total = 0;
    int   pulse_cyc_q[$];
    int   cyc         = 0;
    int   dbl_cnt     = 0;
    int   bad_cnt     = 0;
    logic last_bs     = 1'b0;

    function automatic logic [7:0] rotl8(input logic [7:0] w, input int n);
        logic [7:0] r;
        r = w;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [7:0] rand_bad();
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (v == TGT) v = v ^ 8'h80;
        return v;
    endfunction

    assign clk_data_out = ovr_en ? ovr_val : rotl8(base_word, (pulse_total - pulse_base) % 8);

    always @(negedge sample_clk) begin
        cyc <= cyc + 1;
        last_bs <= bitslip;
        if (bitslip) begin
            pulse_total <= pulse_total + 1;
            pulse_cyc_q.push_back(cyc);
            if (last_bs) dbl_cnt <= dbl_cnt + 1;
            if (aligned || align_err) bad_cnt <= bad_cnt + 1;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sample_clk);
        #1;
    endtask

    // which: 0 aligned, 1 align_err, 2 bitslip. n = edges until seen, -1 on timeout.
    task automatic wait_flag(input int which, output int n);
        logic seen;
        n = -1;
        for (int i = 1; i <= 1000; i++) begin
            tick();
            seen = (which == 0) ? aligned : ((which == 1) ? align_err : bitslip);
            if (seen) begin
                n = i;
                break;
            end
        end
    endtask

    // Leaves the bench just after the IDLE->CHECK edge.
    task automatic start_run(input logic [7:0] w, input logic oe, input logic [7:0] ov);
        enable = 1'b0;
        tick();
        base_word  = w;
        pulse_base = pulse_total;
        ovr_en     = oe;
        ovr_val    = ov;
        enable     = 1'b1;
        tick();
    endtask

    task automatic check_run(input string tag, input int k, input int n);
        int min_low;
        check({tag, "_lock_time"}, n, k * (SETTLE + 2) + LOCKN);
        check({tag, "_pulses"}, pulse_total - pulse_base, k);
        check({tag, "_slip_count"}, int'(slip_count), k);
        check({tag, "_aligned"}, int'(aligned), 1);
        min_low = 1000;
        for (int i = pulse_base + 1; i < pulse_total; i++) begin
            if (pulse_cyc_q[i] - pulse_cyc_q[i-1] - 1 < min_low)
                min_low = pulse_cyc_q[i] - pulse_cyc_q[i-1] - 1;
        end
        if (k >= 2) check({tag, "_min_gap_ok"}, int'(min_low >= SETTLE + 1), 1);
    endtask

    function automatic logic [7:0] needs_slips(input int k);
        return rotl8(TGT, (8 - k) % 8);
    endfunction

    initial begin
        int n;
        int k;
        int p0;

        // Reset with enable high and random input.
        reset_n = 1'b0;
        enable  = 1'b1;
        ovr_en  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ovr_val = 8'($urandom_range(0, 255));
            tick();
        end
        check("rst_bitslip", int'(bitslip), 0);
        check("rst_aligned", int'(aligned), 0);
        check("rst_align_err", int'(align_err), 0);
        check("rst_slip_count", int'(slip_count), 0);
`ifdef FRAME_ALIGNER_STATS_EN
        check("rst_slip_total", int'(slip_total), 0);
        check("rst_lock_losses", int'(lock_losses), 0);
`endif

        // Release with the target word already present: no slips, lock after LOCKN samples.
        base_word  = TGT;
        pulse_base = pulse_total;
        ovr_en     = 1'b0;
        reset_n    = 1'b1;
        tick();
        wait_flag(0, n);
        check_run("direct", 0, n);

        // 8'h3C needs six rotations to reach the target.
        start_run(8'h3C, 1'b0, 8'h00);
        wait_flag(0, n);
        check_run("slip6", 6, n);

        // Short glitch burst must not drop lock.
        for (int i = 0; i < 3; i++) begin
            ovr_en  = 1'b1;
            ovr_val = rand_bad();
            tick();
            check("glitch3_aligned", int'(aligned), 1);
        end
        ovr_en = 1'b0;
        tick();
        check("glitch3_after", int'(aligned), 1);

        // Four consecutive mismatches drop lock on the fourth sample edge.
        for (int i = 0; i < 4; i++) begin
            ovr_en  = 1'b1;
            ovr_val = rand_bad();
            tick();
            check("loss_aligned", int'(aligned), (i < 3) ? 1 : 0);
        end
        check("loss_slip_count", int'(slip_count), 0);
        base_word  = 8'h3C;
        pulse_base = pulse_total;
        ovr_en     = 1'b0;
        wait_flag(0, n);
        check_run("realign", 6, n);
`ifdef FRAME_ALIGNER_STATS_EN
        check("stats_slip_total", int'(slip_total), 12);
        check("stats_lock_losses", int'(lock_losses), 1);
`endif

        // Unalignable word: exactly MAXS pulses then FAIL, held.
        start_run(TGT, 1'b1, 8'h55);
        wait_flag(1, n);
        check("fail_time", n, MAXS * (SETTLE + 2) + 1);
        check("fail_pulses", pulse_total - pulse_base, MAXS);
        check("fail_slip_count", int'(slip_count), MAXS);
        repeat (20) tick();
        check("fail_hold_pulses", pulse_total - pulse_base, MAXS);
        check("fail_hold_err", int'(align_err), 1);
        check("fail_hold_aligned", int'(aligned), 0);
        enable = 1'b0;
        tick();
        check("fail_clr_err", int'(align_err), 0);
        check("fail_clr_slip_count", int'(slip_count), 0);
        k = $urandom_range(0, 7);
        start_run(needs_slips(k), 1'b0, 8'h00);
        wait_flag(0, n);
        check_run("after_fail", k, n);

        // Randomized alignment runs.
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(0, 7);
            start_run(needs_slips(k), 1'b0, 8'h00);
            wait_flag(0, n);
            check_run("rand_run", k, n);
        end

        // Reset asserted during SETTLE.
        start_run(needs_slips(3), 1'b0, 8'h00);
        wait_flag(2, n);
        check("abort_first_slip", n, 1);
        tick();
        reset_n = 1'b0;
        ovr_en  = 1'b1;
        ovr_val = rand_bad();
        tick();
        check("abort_rst_bitslip", int'(bitslip), 0);
        check("abort_rst_aligned", int'(aligned), 0);
        check("abort_rst_align_err", int'(align_err), 0);
        check("abort_rst_slip_count", int'(slip_count), 0);
        base_word  = needs_slips(2);
        pulse_base = pulse_total;
        ovr_en     = 1'b0;
        reset_n    = 1'b1;
        tick();
        wait_flag(0, n);
        check_run("after_rst", 2, n);

        // Enable dropped during SLIP: the pulse completes, nothing follows.
        start_run(needs_slips(5), 1'b0, 8'h00);
        wait_flag(2, n);
        enable = 1'b0;
        tick();
        check("en_drop_bitslip", int'(bitslip), 0);
        check("en_drop_slip_count", int'(slip_count), 0);
        p0 = pulse_total - pulse_base;
        repeat (20) tick();
        check("en_drop_pulses", pulse_total - pulse_base, 1);
        check("en_drop_pulses_then", p0, 1);

        check("no_double_pulse", dbl_cnt, 0);
        check("no_pulse_locked_or_fail", bad_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
